sar_search: RTL and testbench
=============================

# sar_search

Successive-approximation search controller: the driving end of a magnitude comparator. It owns the comparator's B operand and consumes the comparator's greater/equal/less flags. It runs a bit-by-bit binary search until B equals the unknown A operand, then reports the recovered value. It sits beside a combinational magnitude comparator whose A input is the quantity being measured.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of compare-count output
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new search; sampled only when busy=0
- a_greater  in  1  comparator flag: A > trial
- a_equal  in  1  comparator flag: A = trial
- a_less  in  1  comparator flag: A < trial
- trial  out  WIDTH  registered trial value, wired to comparator B
- busy  out  1  search in progress
- done  out  1  one-cycle pulse: result, compares and error valid
- result  out  WIDTH  recovered value of A, held until next done
- compares  out  CNT_W  number of flag samples used by the last search, held
- error  out  1  last search aborted on non-one-hot flags, held

## Operation
- States: IDLE, SEARCH, DONE. Reset → IDLE.
- Reset values: trial=0, busy=0, done=0, result=0, compares=0, error=0. Internal bit pointer = MSB.
- IDLE/DONE with start=1: go to SEARCH, trial = 1<<(WIDTH-1), pointer = WIDTH-1, internal count = 0, busy=1.
- DONE with start=0: go to IDLE. done is high only while in DONE.
- SEARCH, on each edge, sample the flags and increment the count:
  - a_equal only: finish. result=trial, error=0.
  - a_greater only: keep the pointer bit. If pointer>0, set bit pointer-1 and decrement the pointer. Otherwise finish with result=trial.
  - a_less only: clear the pointer bit. If pointer>0, set bit pointer-1 and decrement the pointer. Otherwise finish with result=trial with that bit cleared.
  - Flags not exactly one-hot: finish with error=1 and result=current trial.
- Finish: go to DONE, busy=0, done=1, compares=count including this sample. trial holds its final value.
- start while busy=1 is ignored. Flags are ignored outside SEARCH.
- Asynchronous rst at any time, including mid-search, forces every reset value immediately. No done pulse is issued for the abandoned search.
- All arithmetic is unsigned. The search always terminates in ≤WIDTH samples. The pointer never underflows.

## Timing
- Edge k samples start → trial valid during cycle k..k+1. Flags are sampled at edge k+1.
- The comparator is combinational, so each flag sample sees the trial registered on the previous edge. No settle cycles are added.
- For a search finishing at the n-th sample, done is high in the cycle after edge k+n, with 1 ≤ n ≤ WIDTH. Max start-to-done is WIDTH edges.
- Back-to-back: start high during the done cycle begins a new search at that edge. busy rises on the same edge that done falls.
- result, compares and error update only on the edge entering DONE. They are stable otherwise.

## Structure
- Shared package/header comp_defs: state encodings (IDLE, SEARCH, DONE) and the flag-vector order {greater, equal, less}. This lets comparator-side blocks share one flag convention.
- Single flat module. No sub-module is required. The one-hot flag check stays inline.
- The bench pairs the DUT with a behavioural magnitude comparator on trial vs. a driven A.

## Test plan
- WIDTH=4, A=8, start: trial=8 → a_equal at first sample. done one cycle later, result=8, compares=1, error=0.
- A=0: trials 8,4,2,1, all less. done after edge 4, result=0, compares=4. A=15: trials 8,12,14,15, equal on the 4th sample, result=15, compares=4.
- Sweep A=0..15 back-to-back with start asserted in each done cycle: every result=A, compares≤4, busy never low for more than the done cycle.
- Force flags to 3'b000 on the second sample with A=5: done, error=1, result=trial at that sample (4), compares=2. The next start with valid flags clears error.
- A=11, pulse start again mid-search: ignored, result=11. Assert rst after the 2nd sample: all outputs 0 immediately and no done. A new start afterwards yields 11.

Source files
------------

// File: rtl/comp_defs.sv
// Shared definitions for the comparator-side blocks: search FSM encodings and
// the common {greater, equal, less} flag-vector order.
package comp_defs;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Flag vector bit positions: {greater, equal, less}
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  typedef logic [2:0] flags_t;

  localparam flags_t FLAGS_GT = 3'b100;
  localparam flags_t FLAGS_EQ = 3'b010;
  localparam flags_t FLAGS_LT = 3'b001;

  function automatic logic flags_one_hot(input flags_t f);
    return (f == FLAGS_GT) || (f == FLAGS_EQ) || (f == FLAGS_LT);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a magnitude comparator's
// B operand one bit at a time until it matches A, then reports the value.
module sar_search
  import comp_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_greater,
  input  logic             a_equal,
  input  logic             a_less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] compares,
  output logic             error
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  flags_t           flags;
  logic             flags_ok;
  logic [WIDTH-1:0] ptr_mask;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] trial_next;
  logic [CNT_W-1:0] count_inc;
  logic             last_bit;

  // Current trial with the pointer bit resolved, plus the next bit probed.
  always_comb begin
    flags      = '0;
    flags[FLAG_GT] = a_greater;
    flags[FLAG_EQ] = a_equal;
    flags[FLAG_LT] = a_less;
    flags_ok   = flags_one_hot(flags);
    ptr_mask   = WIDTH'(1) << ptr;
    low_mask   = ptr_mask >> 1;
    decided    = flags[FLAG_LT] ? (trial & ~ptr_mask) : trial;
    trial_next = decided | low_mask;
    count_inc  = count + 1'b1;
    last_bit   = (ptr == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= PTR_MSB;
      count    <= '0;
      trial    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      compares <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_SEARCH;
            trial <= TRIAL_INIT;
            ptr   <= PTR_MSB;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SEARCH: begin
          count <= count_inc;
          if (!flags_ok || flags[FLAG_EQ] || last_bit) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            compares <= count_inc;
            error    <= !flags_ok;
            // On a bad flag vector the trial is reported as-is.
            result   <= flags_ok ? decided : trial;
          end else begin
            trial <= trial_next;
            ptr   <= ptr - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator on trial vs. a driven A, with
// expected results derived from the value of A alone.
module tb_sar_search;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          a_greater, a_equal, a_less;
  logic [W-1:0]  trial;
  logic          busy, done, error;
  logic [W-1:0]  result;
  logic [CW-1:0] compares;

  int            a_val = 0;
  logic          force_en = 1'b0;
  logic [2:0]    force_flags = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .compares(compares), .error(error)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_en) begin
      {a_greater, a_equal, a_less} = force_flags;
    end else begin
      a_greater = (a_val >  int'(trial));
      a_equal   = (a_val == int'(trial));
      a_less    = (a_val <  int'(trial));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // A binary search ends once every bit down to A's lowest set bit is decided.
  function automatic int exp_compares(input int a);
    int t = 0;
    if (a == 0) return W;
    while (((a >> t) & 1) == 0) t++;
    return W - t;
  endfunction

  // Waits for done; edges counts clock edges waited; gap counts idle cycles.
  task automatic wait_done(output int edges, output int gap);
    edges = 0;
    gap   = 0;
    for (int e = 1; e <= W + 3; e++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = e;
        break;
      end
      if (!busy) gap++;
    end
    if (edges == 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_search(input int a);
    int edges, gap;
    @(negedge clk);
    a_val = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("trial_first", int'(trial), 1 << (W - 1));
    wait_done(edges, gap);
    check("latency", edges, exp_compares(a));
    check("result", int'(result), a);
    check("compares", int'(compares), exp_compares(a));
    check("error_clear", int'(error), 0);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("held_result", int'(result), a);
  endtask

  initial begin
    int edges, gap, a;

    #2;
    check("rst_trial", int'(trial), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_compares", int'(compares), 0);
    check("rst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_search(8);
    run_search(0);
    run_search(15);

    // Back-to-back sweep with start held high through every done cycle.
    @(negedge clk);
    a_val = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      wait_done(edges, gap);
      check("sweep_latency", edges, exp_compares(i) + (i > 0 ? 1 : 0));
      check("sweep_result", int'(result), i);
      check("sweep_compares", int'(compares), exp_compares(i));
      check("sweep_gap", gap, 0);
      a_val = (i + 1) & 15;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("sweep_idle", int'(busy), 0);

    // Bad flags on the second sample: reported as error with the trial of the time.
    @(negedge clk);
    a_val = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    force_en = 1'b1;
    force_flags = 3'b000;
    @(posedge clk); #1;
    force_en = 1'b0;
    check("err_done", int'(done), 1);
    check("err_flag", int'(error), 1);
    check("err_result", int'(result), 4);
    check("err_compares", int'(compares), 2);
    run_search(5);

    // A second start mid-search is ignored.
    @(negedge clk);
    a_val = 11;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(edges, gap);
    check("ign_result", int'(result), 11);
    check("ign_compares", int'(compares), exp_compares(11));
    check("ign_latency", edges, exp_compares(11) - 2);

    // Reset mid-search clears everything at once and drops the search.
    @(negedge clk);
    a_val = 11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_trial", int'(trial), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_compares", int'(compares), 0);
    check("mid_rst_error", int'(error), 0);
    gap = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (done) gap++;
    end
    check("mid_rst_no_done", gap, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done) gap++;
    end
    check("post_rst_no_done", gap, 0);
    run_search(11);

    for (int r = 0; r < 24; r++) begin
      a = int'($urandom_range(0, 15));
      run_search(a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
